wb_single_master: RTL and testbench

WB_SINGLE_MASTER -- requirements
Module: wb_single_master

---
 rtl/wb_single_master.sv | 153 +++++++++++++++
 tb/tb_wb_single_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_single_master.sv
// Single-transfer Wishbone classic master: accepts one command, runs one bus cycle with
// retry/backoff and timeout handling, then presents one response.
module wb_single_master #(
    parameter int wb_dat_width   = 8,
    parameter int wb_adr_width   = 3,
    parameter int timeout_cycles = 255,
    parameter int max_retries    = 3
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [wb_adr_width-1:0] cmd_adr,
    input  logic [wb_dat_width-1:0] cmd_dat,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [wb_dat_width-1:0] rsp_dat,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [wb_adr_width-1:0] wb_adr_o,
    output logic [wb_dat_width-1:0] wb_dat_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [wb_dat_width-1:0] wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        BACKOFF,
        RESP
    } state_t;

    localparam logic [3:0] MaxRetry    = 4'(max_retries);
    localparam logic [7:0] TimeoutLast = 8'(timeout_cycles - 1);

    state_t                  state_q, state_d;
    logic                    live_q;
    logic                    we_q, we_d;
    logic [wb_adr_width-1:0] adr_q, adr_d;
    logic [wb_dat_width-1:0] dat_q, dat_d;
    logic [3:0]              retryCnt_q, retryCnt_d;
    logic [7:0]              toCnt_q, toCnt_d;
    logic [wb_dat_width-1:0] rspDat_q, rspDat_d;
    logic                    rspErr_q, rspErr_d;
    logic                    rspTimeout_q, rspTimeout_d;

    // live_q delays command acceptance by one edge so reset release is seen synchronously
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            live_q       <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            retryCnt_q   <= '0;
            toCnt_q      <= '0;
            rspDat_q     <= '0;
            rspErr_q     <= 1'b0;
            rspTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_q       <= 1'b1;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            retryCnt_q   <= retryCnt_d;
            toCnt_q      <= toCnt_d;
            rspDat_q     <= rspDat_d;
            rspErr_q     <= rspErr_d;
            rspTimeout_q <= rspTimeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        retryCnt_d   = retryCnt_q;
        toCnt_d      = toCnt_q;
        rspDat_d     = rspDat_q;
        rspErr_d     = rspErr_q;
        rspTimeout_d = rspTimeout_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_d       = cmd_we;
                    adr_d      = cmd_adr;
                    dat_d      = cmd_dat;
                    retryCnt_d = '0;
                    toCnt_d    = '0;
                    state_d    = BUS;
                end
            end
            BUS: begin
                // err beats ack beats rty; any of them beats the timeout on the same cycle
                if (wb_err_i || (wb_rty_i && !wb_ack_i && retryCnt_q == MaxRetry)) begin
                    rspDat_d     = '0;
                    rspErr_d     = 1'b1;
                    rspTimeout_d = 1'b0;
                    state_d      = RESP;
                end else if (wb_ack_i) begin
                    rspDat_d     = we_q ? '0 : wb_dat_i;
                    rspErr_d     = 1'b0;
                    rspTimeout_d = 1'b0;
                    state_d      = RESP;
                end else if (wb_rty_i) begin
                    retryCnt_d = retryCnt_q + 4'd1;
                    state_d    = BACKOFF;
                end else if (toCnt_q == TimeoutLast) begin
                    rspDat_d     = '0;
                    rspErr_d     = 1'b1;
                    rspTimeout_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    toCnt_d = toCnt_q + 8'd1;
                end
            end
            BACKOFF: begin
                toCnt_d = '0;
                state_d = BUS;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = live_q && (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_dat     = rspDat_q;
    assign rsp_err     = rspErr_q;
    assign rsp_timeout = rspTimeout_q;
    assign wb_cyc_o    = (state_q == BUS);
    assign wb_stb_o    = (state_q == BUS);
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_cti_o    = 3'b000;
    assign wb_bte_o    = 2'b00;

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master: drives the command/response and responder sides by hand
// and compares against hand-computed values.
module tb_wb_single_master;

    logic       wb_clk;
    logic       wb_rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [2:0] cmd_adr;
    logic [7:0] cmd_dat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_dat;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_we_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic [2:0] wb_cti_o;
    logic [1:0] wb_bte_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;
    logic       wb_err_i;
    logic       wb_rty_i;

    int checkCount = 0;
    int passCount  = 0;

    wb_single_master dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cti_o    (wb_cti_o),
        .wb_bte_o    (wb_bte_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_rty_i    (wb_rty_i)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    // Present one command for exactly one edge; caller makes sure cmd_ready is high
    task automatic applyStimulus(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic finishResponse();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("handshake.rsp_valid", rsp_valid, 1'b0);
        checkOutput("handshake.cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        int n;
        wb_rst_n  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        rsp_ready = 1'b0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_rty_i  = 1'b0;
        #1 wb_rst_n = 1'b0;
        #2;
        $display("[TB] reset state");
        checkOutput("rst.cmd_ready", cmd_ready, 1'b0);
        checkOutput("rst.cyc", wb_cyc_o, 1'b0);
        checkOutput("rst.rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst.cti", wb_cti_o, 3'b000);
        checkOutput("rst.bte", wb_bte_o, 2'b00);
        @(posedge wb_clk);
        #2 wb_rst_n = 1'b1;
        #1 checkOutput("release.cmd_ready_before_edge", cmd_ready, 1'b0);
        step();
        checkOutput("release.cmd_ready_after_edge", cmd_ready, 1'b1);

        $display("[TB] write adr 0 dat A5");
        applyStimulus(1'b1, 3'd0, 8'hA5);
        checkOutput("wr.cyc", wb_cyc_o, 1'b1);
        checkOutput("wr.stb", wb_stb_o, 1'b1);
        checkOutput("wr.we", wb_we_o, 1'b1);
        checkOutput("wr.dat_o", wb_dat_o, 8'hA5);
        checkOutput("wr.adr_o", wb_adr_o, 3'd0);
        checkOutput("wr.cmd_ready_busy", cmd_ready, 1'b0);
        step();
        checkOutput("wr.rsp_valid_early", rsp_valid, 1'b0);
        checkOutput("wr.stb_stable", wb_stb_o, 1'b1);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        checkOutput("wr.rsp_valid", rsp_valid, 1'b1);
        checkOutput("wr.rsp_err", rsp_err, 1'b0);
        checkOutput("wr.rsp_dat", rsp_dat, 8'h00);
        checkOutput("wr.cyc_low", wb_cyc_o, 1'b0);
        finishResponse();

        $display("[TB] read adr 1 returns 3C");
        applyStimulus(1'b0, 3'd1, 8'hFF);
        checkOutput("rd.we", wb_we_o, 1'b0);
        checkOutput("rd.adr_o", wb_adr_o, 3'd1);
        step();
        wb_dat_i = 8'h3C;
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        checkOutput("rd.rsp_valid", rsp_valid, 1'b1);
        checkOutput("rd.rsp_dat", rsp_dat, 8'h3C);
        checkOutput("rd.rsp_err", rsp_err, 1'b0);
        checkOutput("rd.cyc_low", wb_cyc_o, 1'b0);
        checkOutput("rd.stb_low", wb_stb_o, 1'b0);
        finishResponse();

        $display("[TB] read with two retries");
        applyStimulus(1'b0, 3'd5, 8'h00);
        wb_rty_i = 1'b1;
        step();
        wb_rty_i = 1'b0;
        checkOutput("rty1.backoff_cyc", wb_cyc_o, 1'b0);
        step();
        checkOutput("rty1.rebus_cyc", wb_cyc_o, 1'b1);
        checkOutput("rty1.adr_o", wb_adr_o, 3'd5);
        wb_rty_i = 1'b1;
        step();
        wb_rty_i = 1'b0;
        checkOutput("rty2.backoff_cyc", wb_cyc_o, 1'b0);
        step();
        checkOutput("rty2.rebus_cyc", wb_cyc_o, 1'b1);
        checkOutput("rty2.adr_o", wb_adr_o, 3'd5);
        wb_dat_i = 8'h5A;
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        checkOutput("rty.rsp_valid", rsp_valid, 1'b1);
        checkOutput("rty.rsp_dat", rsp_dat, 8'h5A);
        checkOutput("rty.rsp_err", rsp_err, 1'b0);
        finishResponse();

        $display("[TB] read with four consecutive retries");
        applyStimulus(1'b0, 3'd2, 8'h00);
        wb_rty_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checkOutput("rty4.rsp_valid_early", rsp_valid, 1'b0);
        checkOutput("rty4.last_bus_cyc", wb_cyc_o, 1'b1);
        step();
        wb_rty_i = 1'b0;
        checkOutput("rty4.rsp_valid", rsp_valid, 1'b1);
        checkOutput("rty4.rsp_err", rsp_err, 1'b1);
        checkOutput("rty4.rsp_timeout", rsp_timeout, 1'b0);
        checkOutput("rty4.rsp_dat", rsp_dat, 8'h00);
        finishResponse();

        $display("[TB] timeout with silent responder");
        applyStimulus(1'b1, 3'd7, 8'h11);
        n = 0;
        while (wb_cyc_o && n < 300) begin
            step();
            n++;
        end
        checkOutput("to.bus_cycles", n, 255);
        checkOutput("to.rsp_valid", rsp_valid, 1'b1);
        checkOutput("to.rsp_err", rsp_err, 1'b1);
        checkOutput("to.rsp_timeout", rsp_timeout, 1'b1);
        checkOutput("to.rsp_dat", rsp_dat, 8'h00);
        finishResponse();

        $display("[TB] ack and err together, response held");
        applyStimulus(1'b0, 3'd3, 8'h00);
        wb_dat_i = 8'h77;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        step();
        wb_err_i  = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold.rsp_valid", rsp_valid, 1'b1);
            checkOutput("hold.rsp_err", rsp_err, 1'b1);
            checkOutput("hold.rsp_dat", rsp_dat, 8'h00);
            checkOutput("hold.cmd_ready", cmd_ready, 1'b0);
            step();
        end
        checkOutput("hold.rsp_timeout", rsp_timeout, 1'b0);
        checkOutput("hold.cyc_ignored_ack", wb_cyc_o, 1'b0);
        cmd_valid = 1'b0;
        wb_ack_i  = 1'b0;
        wb_dat_i  = 8'h00;
        finishResponse();

        $display("[TB] reset during bus cycle");
        applyStimulus(1'b1, 3'd2, 8'h11);
        checkOutput("mid.cyc_before", wb_cyc_o, 1'b1);
        #2 wb_rst_n = 1'b0;
        #1;
        checkOutput("mid.cyc", wb_cyc_o, 1'b0);
        checkOutput("mid.stb", wb_stb_o, 1'b0);
        checkOutput("mid.adr_o", wb_adr_o, 3'd0);
        checkOutput("mid.cmd_ready", cmd_ready, 1'b0);
        @(posedge wb_clk);
        #2 wb_rst_n = 1'b1;
        #1 checkOutput("mid.cmd_ready_release", cmd_ready, 1'b0);
        step();
        checkOutput("mid.cmd_ready_edge", cmd_ready, 1'b1);
        applyStimulus(1'b1, 3'd3, 8'h42);
        checkOutput("post.cyc", wb_cyc_o, 1'b1);
        checkOutput("post.dat_o", wb_dat_o, 8'h42);
        step();
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        checkOutput("post.rsp_valid", rsp_valid, 1'b1);
        checkOutput("post.rsp_err", rsp_err, 1'b0);
        finishResponse();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
